// File: rtl/tff_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tff_counter_ctrl
//
// Sequencer for an external bank of WIDTH toggle flip-flops. The bank's next
// value is cnt_q ^ t_en, so driving t_en = cnt_q ^ X forces the bank to X on the
// next edge. Driving the per-bit carry pattern instead steps it by one. The
// block uses this to run the bank as an up/down counter with load, limit
// detect, one-shot and auto-reload modes.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   start        in   begin a run (sampled in IDLE / DONE)
//   stop         in   abort a run, or leave DONE
//   dir          in   1 = up, 0 = down (latched on start)
//   auto_reload  in   reload at limit and keep running (latched on start)
//   reload_val   in   [WIDTH] start / reload value (latched on start)
//   limit        in   [WIDTH] terminal value (latched on start)
//   cnt_q        in   [WIDTH] Q outputs of the T-FF bank
//   t_en         out  [WIDTH] T inputs of the T-FF bank (combinational)
//   busy         out  high in LOAD and RUN (registered)
//   done         out  high in DONE (registered)
//   tc_pulse     out  terminal-count strobe (combinational)
// -----------------------------------------------------------------------------
module tff_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] reload_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [WIDTH-1:0] t_en,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             latch_cfg;
  logic             at_limit;

  logic             dir_l;
  logic             auto_reload_l;
  logic [WIDTH-1:0] reload_val_l;
  logic [WIDTH-1:0] limit_l;

  // Toggle pattern for a +/-1 step: bit i toggles when every lower bit is
  // 1 (counting up) or 0 (counting down). Wrap falls out modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] step_en(input logic [WIDTH-1:0] q,
                                               input logic up);
    logic [WIDTH-1:0] en;
    logic             carry;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      en[i] = carry;
      carry = carry & (up ? q[i] : ~q[i]);
    end
    return en;
  endfunction

  assign at_limit = (cnt_q == limit_l);

  always_comb begin
    state_nxt = state;
    t_en      = '0;
    tc_pulse  = 1'b0;
    latch_cfg = 1'b0;
    case (state)
      S_INIT: begin
        // Toggle every set bit: clears the bank regardless of power-up value.
        t_en      = cnt_q;
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (start) begin
          latch_cfg = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        t_en      = cnt_q ^ reload_val_l;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        // stop outranks the limit check, so an aborted run never strobes.
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (at_limit) begin
          tc_pulse = 1'b1;
          if (auto_reload_l) begin
            t_en = cnt_q ^ reload_val_l;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          t_en = step_en(cnt_q, dir_l);
        end
      end
      S_DONE: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (start) begin
          latch_cfg = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  // State register; busy/done are decoded from the next state so they line up
  // with the state they describe without a combinational path to the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_INIT;
      busy          <= 1'b0;
      done          <= 1'b0;
      dir_l         <= 1'b0;
      auto_reload_l <= 1'b0;
      reload_val_l  <= '0;
      limit_l       <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
      done  <= (state_nxt == S_DONE);
      if (latch_cfg) begin
        dir_l         <= dir;
        auto_reload_l <= auto_reload;
        reload_val_l  <= reload_val;
        limit_l       <= limit;
      end
    end
  end

endmodule

// File: doc/tff_counter_ctrl.md
Name: tff_counter_ctrl

Overview:
- Synchronous sequencer for an external bank of WIDTH T flip-flops. The bank has one T_ff per bit, shares clk, and has its rstn tied inactive.
- Each cycle the block reads the bank state (cnt_q) and drives the per-bit toggle enables (t_en). This turns the bank into a programmable up/down counter with load, limit detect, one-shot and auto-reload modes.
- Sits between host control logic and the T-FF counter datapath.

Parameters:
- WIDTH, 4, counter bit width. Also the width of cnt_q, t_en, limit and reload_val.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a count run. Sampled in IDLE/DONE.
- stop  in  1  abort a run, or leave DONE.
- dir  in  1  1 = count up, 0 = count down. Latched on start.
- auto_reload  in  1  1 = reload at limit and continue. Latched on start.
- reload_val  in  WIDTH  start/reload value. Latched on start.
- limit  in  WIDTH  terminal value. Latched on start.
- cnt_q  in  WIDTH  Q outputs of the T-FF bank.
- t_en  out  WIDTH  T inputs of the T-FF bank. Combinational.
- busy  out  1  high in LOAD and RUN. Registered decode.
- done  out  1  high in DONE. Registered decode.
- tc_pulse  out  1  terminal-count strobe. Combinational, one cycle.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high. On rst, state goes to INIT, latched config clears to 0, and busy = done = 0.
- Toggle rule: the bank's next value is cnt_q ^ t_en. Setting t_en = cnt_q ^ X therefore forces the count to X on the next edge.
- Step function:
  - Up: t_en[0] = 1; t_en[i] = &cnt_q[i-1:0].
  - Down: t_en[0] = 1; t_en[i] = &(~cnt_q[i-1:0]).
  - Wrap is modulo 2^WIDTH: up from all-ones gives 0, down from 0 gives all-ones.
- INIT: t_en = cnt_q, which clears the bank to 0. Always goes to IDLE next cycle.
- IDLE: t_en = 0.
  - start = 1: latch dir, auto_reload, reload_val and limit; go to LOAD.
  - stop is ignored. start wins if both are high.
- LOAD: t_en = cnt_q ^ reload_val_l; go to RUN. cnt_q equals reload_val_l in the first RUN cycle.
- RUN, checked in priority order:
  1. stop = 1: t_en = 0, go to IDLE, count holds. No tc_pulse, even if cnt_q == limit_l.
  2. cnt_q == limit_l: tc_pulse = 1.
     - auto_reload_l = 1: t_en = cnt_q ^ reload_val_l, stay in RUN.
     - Otherwise: t_en = 0, go to DONE.
  3. Else: t_en = step(dir_l).
- DONE: t_en = 0, count holds at limit_l.
  - stop = 1: go to IDLE (stop wins over start).
  - Else start = 1: latch new config, go to LOAD.
- Latency: start sampled at edge n gives LOAD during cycle n+1, the first counted value (reload_val) during n+2, and one step per cycle after that.
- A limit that is unreachable in the chosen direction still terminates after wrap. The maximum run length is 2^WIDTH steps.
- reload_val == limit:
  - One-shot: tc_pulse in the first RUN cycle, then DONE.
  - Auto-reload: tc_pulse every RUN cycle and the count holds.
- Host inputs are ignored except in the states listed above. Config changes while busy have no effect.
- rst mid-run: INIT on the next cycle, the bank clears to 0 one edge later, then IDLE. There are no spurious tc_pulse or done outputs during this.
- tc_pulse and t_en are valid only after cnt_q settles. The T-FF simulation C2Q delay must be less than the clock period.

Test Plan:
- WIDTH = 4, rst, then idle 2 cycles -> bank reads 0; busy = done = tc_pulse = 0; t_en = 0 in IDLE.
- dir = 1, reload_val = 3, limit = 6, auto_reload = 0, pulse start -> cnt_q 3,4,5,6; tc_pulse exactly once (at cnt_q = 6); done = 1 and count holds at 6; busy low in DONE.
- Same run with auto_reload = 1 -> cnt_q 3,4,5,6,3,4,5,6,...; tc_pulse each time cnt_q = 6; done stays 0.
- dir = 0, reload_val = 2, limit = 13 -> cnt_q 2,1,0,15,14,13 (wrap-through); then DONE.
- stop asserted while cnt_q = 5 in an up run with limit = 9 -> IDLE next cycle, count holds at 5, no tc_pulse. start and stop together in IDLE -> LOAD.
- rst asserted while cnt_q = 10 in RUN -> INIT, bank reaches 0 one edge later, then IDLE; busy drops on the cycle after rst is sampled.
